// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the mode-0 SPI responder.
package spi_pkg;

    localparam int DEFAULT_WIDTH       = 13;
    localparam int DEFAULT_SYNC_STAGES = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin, with optional registered
// rise/fall strobes that line up with the delayed level output.
module spi_sync_edge #(
    parameter int STAGES  = 2,
    parameter bit EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic dout_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbour and the chain shifts by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din_i};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    // The extra stage keeps the level output aligned with the edge strobes.
    assign dout_o = dly_q;

    generate
        if (EDGE_EN) begin : g_edge
            logic rise_q;
            logic fall_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                end else begin
                    rise_q <= sync_q[STAGES-1] & ~dly_q;
                    fall_q <= ~sync_q[STAGES-1] & dly_q;
                end
            end

            assign rise_o = rise_q;
            assign fall_o = fall_q;
        end else begin : g_no_edge
            assign rise_o = 1'b0;
            assign fall_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/spi_slave.sv
// Mode-0, MSB-first SPI responder running in the clk domain; oversamples the
// SPI pins and exchanges one WIDTH-bit word per frame.
module spi_slave
    import spi_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             mosi,
    input  logic             ss_n,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_dat,
    input  logic             load,
    output logic [WIDTH-1:0] rx_dat,
    output logic             rx_valid,
    output logic             busy
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic sclk_rise, sclk_fall, mosi_s, ss_s;
    logic unused_sclk_s, unused_mosi_rise, unused_mosi_fall;
    logic unused_ss_rise, unused_ss_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_sclk (
        .clk(clk), .rst(rst), .din_i(sclk),
        .dout_o(unused_sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din_i(mosi),
        .dout_o(mosi_s), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_ss (
        .clk(clk), .rst(rst), .din_i(ss_n),
        .dout_o(ss_s), .rise_o(unused_ss_rise), .fall_o(unused_ss_fall)
    );

    spi_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-2:0] rx_shift_q;
    logic [WIDTH-2:0] tx_shift_q;
    logic [WIDTH-1:0] rx_dat_q;
    logic             rx_valid_q;
    logic             miso_q;
    logic [WIDTH-1:0] rx_next;

    assign rx_next = {rx_shift_q, mosi_s};

    // {miso_q, tx_shift_q} is the transmit shift register; its MSB is the pin.
    // NOTE: reset is synchronous and covers every shift/data register, so a
    // mid-frame reset leaves no stale bits in the datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            rx_dat_q   <= '0;
            rx_valid_q <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sclk_rise && !ss_s) begin
                        rx_shift_q <= rx_next[WIDTH-2:0];
                        cnt_q      <= CNT_W'(1);
                        state_q    <= SHIFT;
                    end else if (load && !sclk_rise) begin
                        {miso_q, tx_shift_q} <= tx_dat;
                    end
                end
                SHIFT: begin
                    if (ss_s) begin
                        cnt_q                <= '0;
                        {miso_q, tx_shift_q} <= '0;
                        state_q              <= IDLE;
                    end else if (sclk_rise) begin
                        rx_shift_q <= rx_next[WIDTH-2:0];
                        if (cnt_q == LAST_CNT) begin
                            rx_dat_q             <= rx_next;
                            rx_valid_q           <= 1'b1;
                            cnt_q                <= '0;
                            {miso_q, tx_shift_q} <= '0;
                            state_q              <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else if (sclk_fall) begin
                        {miso_q, tx_shift_q} <= {tx_shift_q, 1'b0};
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign miso     = miso_q;
    assign rx_dat   = rx_dat_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table-driven full frames plus hand-written
// abort, reset, busy-load and deselected-clock sequences.
module tb_spi_slave;

    localparam int W = 13;

    logic         clk = 1'b0;
    logic         rst;
    logic         sclk;
    logic         mosi;
    logic         ss_n;
    logic         load;
    logic [W-1:0] tx_dat;
    logic         miso;
    logic [W-1:0] rx_dat;
    logic         rx_valid;
    logic         busy;

    spi_slave #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
        .miso(miso), .tx_dat(tx_dat), .load(load),
        .rx_dat(rx_dat), .rx_valid(rx_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int valid_cnt = 0;
    bit busy_seen = 1'b0;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) valid_cnt++;
        if (busy === 1'b1) busy_seen = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [W-1:0] word);
        @(negedge clk);
        tx_dat = word;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("load_to_miso", 32'(miso), 32'(word[W-1]));
    endtask

    // Mode-0 master, half period of 4 clk; samples miso just before each rise.
    // load_at >= 0 pulses load with all-ones in the low half after that bit.
    task automatic xfer(input logic [W-1:0] mosi_word, input int nbits,
                        input int load_at, output logic [W-1:0] cap);
        logic [W-1:0] m;
        m    = mosi_word;
        cap  = '0;
        mosi = m[W-1];
        wait_clk(4);
        for (int i = 0; i < nbits; i++) begin
            cap  = {cap[W-2:0], miso};
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
            m    = {m[W-2:0], 1'b0};
            mosi = m[W-1];
            if (i == load_at) begin
                @(negedge clk);
                tx_dat = '1;
                load   = 1'b1;
                @(negedge clk);
                load = 1'b0;
                wait_clk(2);
            end else begin
                wait_clk(4);
            end
        end
    endtask

    typedef struct {
        logic         do_ld;
        logic [W-1:0] tx;
        logic [W-1:0] m_out;
        logic [W-1:0] exp_rx;
        logic [W-1:0] exp_miso;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [W-1:0] cap;
        int           v0;

        vecs[0] = '{1'b1, 13'b0101001011001, 13'b1001001001001, 13'b1001001001001, 13'b0101001011001};
        vecs[1] = '{1'b0, 13'h0000, 13'h0AAA, 13'h0AAA, 13'h0000};
        vecs[2] = '{1'b1, 13'h1FFF, 13'h0000, 13'h0000, 13'h1FFF};
        vecs[3] = '{1'b1, 13'h0001, 13'h1FFF, 13'h1FFF, 13'h0001};
        vecs[4] = '{1'b1, 13'h1234, 13'h0F0F, 13'h0F0F, 13'h1234};

        rst = 1'b1; sclk = 1'b0; mosi = 1'b0; ss_n = 1'b0; load = 1'b0; tx_dat = '0;
        wait_clk(4);
        rst = 1'b0;
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_rx_dat", 32'(rx_dat), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        wait_clk(4);

        // Full frames; entry 1 follows entry 0 with no load, so it sends zeros.
        for (int k = 0; k < 5; k++) begin
            v0 = valid_cnt;
            if (vecs[k].do_ld) do_load(vecs[k].tx);
            xfer(vecs[k].m_out, W, -1, cap);
            wait_clk(4);
            check($sformatf("vec%0d_rx_dat", k), 32'(rx_dat), 32'(vecs[k].exp_rx));
            check($sformatf("vec%0d_master_rx", k), 32'(cap), 32'(vecs[k].exp_miso));
            check($sformatf("vec%0d_valid_pulses", k), 32'(valid_cnt - v0), 32'd1);
            check($sformatf("vec%0d_busy_after", k), 32'(busy), 32'd0);
        end

        // load during a frame must not disturb the bits being shifted out
        do_load(13'h0A5A);
        xfer(13'h1111, W, 3, cap);
        wait_clk(4);
        check("busy_load_master_rx", 32'(cap), 32'h0A5A);
        check("busy_load_rx_dat", 32'(rx_dat), 32'h1111);

        // abort after 6 bits
        v0 = valid_cnt;
        do_load(13'h1555);
        xfer(13'h0F00, 6, -1, cap);
        check("abort_busy_before", 32'(busy), 32'd1);
        ss_n = 1'b1;
        wait_clk(8);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("abort_rx_dat_kept", 32'(rx_dat), 32'h1111);
        check("abort_miso_cleared", 32'(miso), 32'd0);
        ss_n = 1'b0;
        wait_clk(6);
        v0 = valid_cnt;
        do_load(13'h0ABC);
        xfer(13'h1ACE, W, -1, cap);
        wait_clk(4);
        check("post_abort_rx_dat", 32'(rx_dat), 32'h1ACE);
        check("post_abort_master_rx", 32'(cap), 32'h0ABC);
        check("post_abort_valid", 32'(valid_cnt - v0), 32'd1);

        // reset in the middle of a frame
        do_load(13'h1FFF);
        xfer(13'h1555, 5, -1, cap);
        check("midrst_busy_before", 32'(busy), 32'd1);
        check("midrst_miso_before", 32'(miso), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_miso", 32'(miso), 32'd0);
        check("midrst_rx_dat", 32'(rx_dat), 32'd0);
        check("midrst_rx_valid", 32'(rx_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);

        // sclk activity while deselected is ignored
        ss_n = 1'b1;
        wait_clk(6);
        do_load(13'h1555);
        v0 = valid_cnt;
        busy_seen = 1'b0;
        xfer(13'h1FFF, W, -1, cap);
        wait_clk(4);
        check("desel_busy_seen", 32'(busy_seen), 32'd0);
        check("desel_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("desel_miso_held", 32'(miso), 32'd1);
        check("desel_rx_dat", 32'(rx_dat), 32'd0);

        // reselect: the preloaded word is still pending and goes out
        ss_n = 1'b0;
        wait_clk(6);
        v0 = valid_cnt;
        xfer(13'h0C3A, W, -1, cap);
        wait_clk(4);
        check("resel_rx_dat", 32'(rx_dat), 32'h0C3A);
        check("resel_master_rx", 32'(cap), 32'h1555);
        check("resel_valid", 32'(valid_cnt - v0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
